// File: rtl/serial_word_rx.sv
// Serial frame receiver: start(1), WIDTH data bits MSB first, optional parity, stop(0).
// Define PARITY_CHECK_EN to compile in the even-parity bit and check.
module serial_word_rx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             framing_err,
   output logic             parity_err,
   output logic             overrun
);

   // state  | meaning
   // IDLE   | waiting for a qualified start bit (1)
   // SHIFT  | collecting WIDTH data bits, MSB first
   // PARITY | collecting the parity bit (PARITY_CHECK_EN only)
   // STOP   | checking the stop bit (0) and delivering the word
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
      ST_PARITY = 2'd2,
`endif
      ST_STOP   = 2'd3
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_ferr;
   logic             r_ovr;
`ifdef PARITY_CHECK_EN
   logic             r_par;
   logic             r_perr;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_par   <= 1'b0;
         r_perr  <= 1'b0;
`endif
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_perr <= 1'b0;
`endif
         if (r_valid && dout_ready)
            r_valid <= 1'b0;

         if (din_en) begin
            case (r_state)
               ST_IDLE: begin
                  if (din) begin
                     r_state <= ST_SHIFT;
                     r_cnt   <= '0;
                     r_shift <= '0;
                  end
               end
               ST_SHIFT: begin
                  r_shift <= {r_shift[WIDTH-2:0], din};
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end
               end
`ifdef PARITY_CHECK_EN
               ST_PARITY: begin
                  r_par   <= din;
                  r_state <= ST_STOP;
               end
`endif
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (din)
                     r_ferr <= 1'b1;
`ifdef PARITY_CHECK_EN
                  else if (^{r_shift, r_par})
                     r_perr <= 1'b1;
`endif
                  // a same-edge handshake frees the holding register for the new word
                  else if (!r_valid || dout_ready) begin
                     r_dout  <= r_shift;
                     r_valid <= 1'b1;
                  end else
                     r_ovr <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign dout        = r_dout;
   assign dout_valid  = r_valid;
   assign busy        = (r_state != ST_IDLE);
   assign framing_err = r_ferr;
   assign overrun     = r_ovr;
`ifdef PARITY_CHECK_EN
   assign parity_err  = r_perr;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (WIDTH=8) with a word scoreboard queue.
// Honors PARITY_CHECK_EN in the same way as the design.
module tb_serial_word_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic       din_en;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       framing_err;
   logic       parity_err;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] sb_q[$];

`ifdef PARITY_CHECK_EN
   localparam int FRAME_LEN = 11;
`else
   localparam int FRAME_LEN = 10;
`endif

   serial_word_rx #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .din(din), .din_en(din_en),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .busy(busy), .framing_err(framing_err), .parity_err(parity_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [7:0] e;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = 'x;
      chk(tag, {24'd0, dout}, {24'd0, e});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one frame; leaves time at #1 after the stop-bit edge.
   task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                             input bit toggle, input logic rdy_stop,
                             output int cycles, output logic busy_low);
      logic q[$];
      q.push_back(1'b1);
      for (int i = 7; i >= 0; i--) q.push_back(data[i]);
`ifdef PARITY_CHECK_EN
      q.push_back(par_bit);
`endif
      q.push_back(stop_bit);
      cycles   = 0;
      busy_low = 1'b0;
      for (int k = 0; k < q.size(); k++) begin
         if (toggle) begin
            din    = ~q[k];
            din_en = 1'b0;
            tick();
            cycles++;
            if (k > 0 && !busy) busy_low = 1'b1;
         end
         if (k == q.size() - 1) dout_ready = rdy_stop;
         din    = q[k];
         din_en = 1'b1;
         tick();
         cycles++;
         if (k < q.size() - 1 && !busy) busy_low = 1'b1;
      end
      din_en = 1'b0;
      din    = 1'b0;
   endtask

   initial begin
      int   cyc;
      logic blow;
      logic [7:0] p;

      reset = 1'b0; din = 1'b0; din_en = 1'b0; dout_ready = 1'b0;
      repeat (3) tick();
      chk("rst_dout", {24'd0, dout}, 32'h0);
      chk("rst_valid", {31'd0, dout_valid}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_ferr", {31'd0, framing_err}, 32'h0);
      chk("rst_perr", {31'd0, parity_err}, 32'h0);
      chk("rst_ovr", {31'd0, overrun}, 32'h0);
      reset = 1'b1;
      tick();

      // continuous din_en, consumer ready
      dout_ready = 1'b1;
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, cyc, blow);
      chk("a5_cycles", cyc, FRAME_LEN);
      chk("a5_busy_thru", {31'd0, blow}, 32'h0);
      chk("a5_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("a5_dout");
      chk("a5_busy_end", {31'd0, busy}, 32'h0);
      chk("a5_ferr", {31'd0, framing_err}, 32'h0);
      tick();
      chk("a5_valid_clr", {31'd0, dout_valid}, 32'h0);

      // din_en toggling
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, cyc, blow);
      chk("tog_cycles", cyc, 2 * FRAME_LEN);
      chk("tog_busy_thru", {31'd0, blow}, 32'h0);
      chk("tog_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("tog_dout");
      tick();
      chk("tog_valid_clr", {31'd0, dout_valid}, 32'h0);

      // overrun: holding register full
      dout_ready = 1'b0;
      p = ^8'h3C;
      sb_q.push_back(8'h3C);
      send_frame(8'h3C, p, 1'b0, 1'b0, 1'b0, cyc, blow);
      chk("3c_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("3c_dout");
      p = ^8'hC3;
      send_frame(8'hC3, p, 1'b0, 1'b0, 1'b0, cyc, blow);
      chk("ovr_pulse", {31'd0, overrun}, 32'h1);
      chk("ovr_dout_kept", {24'd0, dout}, 32'h3C);
      chk("ovr_valid", {31'd0, dout_valid}, 32'h1);
      tick();
      chk("ovr_one_cycle", {31'd0, overrun}, 32'h0);
      // completion on a handshake edge
      sb_q.push_back(8'hC3);
      send_frame(8'hC3, p, 1'b0, 1'b0, 1'b1, cyc, blow);
      chk("hs_no_ovr", {31'd0, overrun}, 32'h0);
      chk("hs_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("hs_dout");
      tick();
      chk("hs_valid_clr", {31'd0, dout_valid}, 32'h0);

      // framing error
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1, cyc, blow);
      chk("fe_pulse", {31'd0, framing_err}, 32'h1);
      chk("fe_valid", {31'd0, dout_valid}, 32'h0);
      chk("fe_busy", {31'd0, busy}, 32'h0);
      chk("fe_perr", {31'd0, parity_err}, 32'h0);
      tick();
      chk("fe_one_cycle", {31'd0, framing_err}, 32'h0);

`ifdef PARITY_CHECK_EN
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b1, cyc, blow);
      chk("pe_pulse", {31'd0, parity_err}, 32'h1);
      chk("pe_valid", {31'd0, dout_valid}, 32'h0);
      tick();
      chk("pe_one_cycle", {31'd0, parity_err}, 32'h0);
      sb_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, cyc, blow);
      chk("par_ok_perr", {31'd0, parity_err}, 32'h0);
      chk("par_ok_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("par_ok_dout");
      tick();
`endif

      // leave a word held, then abort a frame with reset
      dout_ready = 1'b0;
      p = ^8'h5A;
      sb_q.push_back(8'h5A);
      send_frame(8'h5A, p, 1'b0, 1'b0, 1'b0, cyc, blow);
      pop_chk("5a_dout");
      din_en = 1'b1;
      din = 1'b1; tick();
      din = 1'b1; tick();
      din = 1'b0; tick();
      din = 1'b1; tick();
      din = 1'b1; tick();
      chk("mid_busy", {31'd0, busy}, 32'h1);
      reset = 1'b0;
      tick();
      chk("mr_dout", {24'd0, dout}, 32'h0);
      chk("mr_valid", {31'd0, dout_valid}, 32'h0);
      chk("mr_busy", {31'd0, busy}, 32'h0);
      reset = 1'b1;
      din = 1'b0;
      tick();
      chk("post_busy", {31'd0, busy}, 32'h0);
      chk("post_ferr", {31'd0, framing_err}, 32'h0);
      chk("post_ovr", {31'd0, overrun}, 32'h0);
      chk("post_valid", {31'd0, dout_valid}, 32'h0);
      din_en = 1'b0;
      p = ^8'h81;
      sb_q.push_back(8'h81);
      send_frame(8'h81, p, 1'b0, 1'b0, 1'b0, cyc, blow);
      chk("81_valid", {31'd0, dout_valid}, 32'h1);
      pop_chk("81_dout");

      chk("sb_empty", sb_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
